// File: rtl/axis_step_arbiter_pkg.sv
// rtl/axis_step_arbiter_pkg.sv - shared owner and FSM state encodings for the step arbiter
package axis_step_arbiter_pkg;

   // Who currently holds the step generator
   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_JOG  = 2'd1,
      OWNER_PROG = 2'd2
   } owner_t;

   // Step generator sequence: optional direction setup, then high and low halves
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DIR_WAIT   = 2'd1,
      ST_PULSE_HIGH = 2'd2,
      ST_PULSE_LOW  = 2'd3
   } state_t;

   localparam int TIMER_W = 32;

endpackage

// File: rtl/axis_step_arbiter_if.sv
// rtl/axis_step_arbiter_if.sv - request and driver-side signals of one step axis
interface axis_step_arbiter_if;
   import axis_step_arbiter_pkg::*;

   logic         jog_fwd;
   logic         jog_rev;
   logic [31:0]  prog_speed;
   logic         prog_dir;
   logic         step_out;
   logic         dir_out;
   logic [1:0]   owner;
   logic         busy;
   logic [31:0]  position;

   // Request source / observer side
   modport master (
      output jog_fwd, jog_rev, prog_speed, prog_dir,
      input  step_out, dir_out, owner, busy, position
   );

   // Arbiter side
   modport slave (
      input  jog_fwd, jog_rev, prog_speed, prog_dir,
      output step_out, dir_out, owner, busy, position
   );

endinterface

// File: rtl/axis_step_arbiter_timer.sv
// rtl/axis_step_arbiter_timer.sv - step_timer: loadable count-down used for half-periods and direction setup
module step_timer
   import axis_step_arbiter_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count;

   // Load N-1 to get an N-cycle interval; counting stops at zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/axis_step_arbiter.sv
// rtl/axis_step_arbiter.sv - one axis: jog/program arbitration and step/dir pulse generation
module axis_step_arbiter
   import axis_step_arbiter_pkg::*;
#(
   parameter int unsigned JOG_HALF  = 50000,
   parameter int unsigned DIR_SETUP = 200
) (
   input  logic                clock,
   input  logic                reset,
   axis_step_arbiter_if.slave  axis
);

   state_t               state;
   state_t               state_next;

   logic                 jog_req;
   logic                 prog_req;
   logic                 any_req;
   owner_t               req_owner;
   logic                 req_dir;
   logic [TIMER_W-1:0]   req_half;

   owner_t               owner_q;
   owner_t               owner_next;
   logic                 dir_q;
   logic                 dir_next;
   logic [TIMER_W-1:0]   half_q;
   logic [TIMER_W-1:0]   half_next;
   logic                 step_q;
   logic                 step_next;
   logic [31:0]          pos_q;
   logic [31:0]          pos_next;

   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_value;
   logic                 timer_done;

   step_timer #(.W(TIMER_W)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   assign jog_req  = axis.jog_fwd ^ axis.jog_rev;
   assign prog_req = (axis.prog_speed != '0);
   assign any_req  = jog_req | prog_req;

   // Fixed-priority request decode: jog beats program
   always_comb begin
      req_owner = OWNER_NONE;
      req_dir   = dir_q;
      req_half  = '0;
      if (jog_req) begin
         req_owner = OWNER_JOG;
         req_dir   = axis.jog_rev;
         req_half  = TIMER_W'(JOG_HALF);
      end else if (prog_req) begin
         req_owner = OWNER_PROG;
         req_dir   = axis.prog_dir;
         req_half  = axis.prog_speed;
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: a pulse, once started, always runs to completion
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (any_req) begin
               if ((req_dir != dir_q) && (DIR_SETUP != 0)) begin
                  state_next = ST_DIR_WAIT;
               end else begin
                  state_next = ST_PULSE_HIGH;
               end
            end
         end
         ST_DIR_WAIT: begin
            if (timer_done) state_next = ST_PULSE_HIGH;
         end
         ST_PULSE_HIGH: begin
            if (timer_done) state_next = ST_PULSE_LOW;
         end
         ST_PULSE_LOW: begin
            if (timer_done) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs: timer loads on each phase entry, grant latched only on IDLE edges
   always_comb begin
      timer_load  = 1'b0;
      timer_value = '0;
      owner_next  = owner_q;
      dir_next    = dir_q;
      half_next   = half_q;
      pos_next    = pos_q;
      step_next   = (state_next == ST_PULSE_HIGH);

      if (state == ST_IDLE) begin
         owner_next = req_owner;
         if (any_req) begin
            dir_next  = req_dir;
            half_next = req_half;
         end
      end

      if ((state == ST_IDLE) && (state_next == ST_DIR_WAIT)) begin
         timer_load  = 1'b1;
         timer_value = TIMER_W'(DIR_SETUP) - 1'b1;
      end else if ((state != ST_PULSE_HIGH) && (state_next == ST_PULSE_HIGH)) begin
         timer_load  = 1'b1;
         timer_value = (state == ST_IDLE) ? (req_half - 1'b1) : (half_q - 1'b1);
         pos_next    = dir_next ? (pos_q - 32'd1) : (pos_q + 32'd1);
      end else if ((state == ST_PULSE_HIGH) && (state_next == ST_PULSE_LOW)) begin
         timer_load  = 1'b1;
         timer_value = half_q - 1'b1;
      end
   end

   // Registered driver outputs and latched grant; reset drops step_out at once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner_q <= OWNER_NONE;
         dir_q   <= 1'b0;
         half_q  <= '0;
         step_q  <= 1'b0;
         pos_q   <= '0;
      end else begin
         owner_q <= owner_next;
         dir_q   <= dir_next;
         half_q  <= half_next;
         step_q  <= step_next;
         pos_q   <= pos_next;
      end
   end

   assign axis.step_out = step_q;
   assign axis.dir_out  = dir_q;
   assign axis.owner    = owner_q;
   assign axis.busy     = (state != ST_IDLE);
   assign axis.position = pos_q;

endmodule

// File: tb/tb_axis_step_arbiter.sv
// tb/tb_axis_step_arbiter.sv - self-checking bench for axis_step_arbiter against a pulse-schedule model
module tb_axis_step_arbiter;

   localparam int unsigned JOG_HALF  = 4;
   localparam int unsigned DIR_SETUP = 3;

   typedef struct {
      logic        step;
      logic        busy;
      logic        dir;
      logic [1:0]  owner;
      logic [31:0] pos;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   axis_step_arbiter_if ifc ();

   axis_step_arbiter #(.JOG_HALF(JOG_HALF), .DIR_SETUP(DIR_SETUP)) dut (
      .clock (clock),
      .reset (reset),
      .axis  (ifc.slave)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   exp_t        sched[$];
   logic        dir_m   = 1'b0;
   logic [1:0]  own_m   = 2'd0;
   logic [31:0] pos_m   = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic step, input logic busy);
      exp_t e;
      e.step  = step;
      e.busy  = busy;
      e.dir   = dir_m;
      e.owner = own_m;
      e.pos   = pos_m;
      sched.push_back(e);
   endtask

   // Expand the request seen in an idle cycle into the full expected step schedule
   task automatic model_eval();
      logic        jog;
      logic        d;
      int unsigned h;
      jog = ifc.jog_fwd ^ ifc.jog_rev;
      if (jog) begin
         own_m = 2'd1;
         d = ifc.jog_rev;
         h = JOG_HALF;
      end else if (ifc.prog_speed != 0) begin
         own_m = 2'd2;
         d = ifc.prog_dir;
         h = ifc.prog_speed;
      end else begin
         own_m = 2'd0;
         return;
      end
      if (d != dir_m) begin
         dir_m = d;
         repeat (DIR_SETUP) push(1'b0, 1'b1);
      end
      pos_m = d ? pos_m - 32'd1 : pos_m + 32'd1;
      repeat (h) push(1'b1, 1'b1);
      repeat (h) push(1'b0, 1'b1);
      push(1'b0, 1'b0);
   endtask

   task automatic step_cycle(input string tag);
      exp_t e;
      if (sched.size() == 0) model_eval();
      @(posedge clock);
      #1;
      if (sched.size() != 0) begin
         e = sched.pop_front();
      end else begin
         e.step = 1'b0; e.busy = 1'b0; e.dir = dir_m; e.owner = own_m; e.pos = pos_m;
      end
      chk({tag, ".step"},  32'(ifc.step_out), 32'(e.step));
      chk({tag, ".busy"},  32'(ifc.busy),     32'(e.busy));
      chk({tag, ".dir"},   32'(ifc.dir_out),  32'(e.dir));
      chk({tag, ".owner"}, 32'(ifc.owner),    32'(e.owner));
      chk({tag, ".pos"},   ifc.position,      e.pos);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step_cycle(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #2;
      chk({tag, ".rst_step"},  32'(ifc.step_out), 32'd0);
      chk({tag, ".rst_dir"},   32'(ifc.dir_out),  32'd0);
      chk({tag, ".rst_owner"}, 32'(ifc.owner),    32'd0);
      chk({tag, ".rst_busy"},  32'(ifc.busy),     32'd0);
      chk({tag, ".rst_pos"},   ifc.position,      32'd0);
      @(posedge clock);
      #1;
      sched.delete();
      dir_m = 1'b0;
      own_m = 2'd0;
      pos_m = 32'd0;
      reset = 1'b0;
   endtask

   task automatic set_in(input logic jf, input logic jr, input logic [31:0] sp, input logic pd);
      ifc.jog_fwd    = jf;
      ifc.jog_rev    = jr;
      ifc.prog_speed = sp;
      ifc.prog_dir   = pd;
   endtask

   initial begin
      set_in(1'b0, 1'b0, 32'd5, 1'b1);
      do_reset("init");

      // Program request, period 5
      set_in(1'b0, 1'b0, 32'd2, 1'b0);
      run("prog2", 16);

      // Reverse jog from reset: direction setup then 4/4
      do_reset("r_jogrev");
      set_in(1'b0, 1'b1, 32'd0, 1'b0);
      run("jogrev", 3);
      chk("jogrev.dirwait_step", 32'(ifc.step_out), 32'd0);
      run("jogrev", 20);

      // Jog pressed mid program pulse waits for the pulse to finish
      do_reset("r_preempt");
      set_in(1'b0, 1'b0, 32'd6, 1'b0);
      run("prog6", 3);
      set_in(1'b1, 1'b0, 32'd6, 1'b0);
      run("preempt", 25);

      // Both jog buttons with no program request: nothing happens
      do_reset("r_both");
      set_in(1'b1, 1'b1, 32'd0, 1'b0);
      run("both", 10);

      // Reset in the second PULSE_HIGH cycle, then H=1
      do_reset("r_mid");
      set_in(1'b0, 1'b0, 32'd3, 1'b0);
      run("mid", 2);
      chk("mid.high_before_rst", 32'(ifc.step_out), 32'd1);
      do_reset("midrst");
      set_in(1'b0, 1'b0, 32'd1, 1'b0);
      run("h1", 12);

      // Position wrap down through zero and back up
      do_reset("r_wrap");
      set_in(1'b0, 1'b1, 32'd0, 1'b0);
      run("wrapdn", 21);
      chk("wrapdn.pos_fffffffe", ifc.position, 32'hFFFF_FFFE);
      set_in(1'b1, 1'b0, 32'd0, 1'b0);
      run("wrapup", 30);

      // Random request changes, including during pulses
      do_reset("r_rand");
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 5)),
                   1'($urandom_range(0, 1)));
         end
         step_cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axis_step_arbiter.md
AXIS_STEP_ARBITER -- requirements
Module: axis_step_arbiter

Interface
REQ-001 Parameter JOG_HALF, default 50000: step half-period in clock cycles used for manual jog.
REQ-002 Parameter DIR_SETUP, default 200: cycles dir_out must be stable, with step_out low, before a rising step edge.
REQ-003 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port jog_fwd  input  1  manual jog request, direction 0 (button-driven, already synchronised upstream).
REQ-006 Port jog_rev  input  1  manual jog request, direction 1.
REQ-007 Port prog_speed  input  32  program step half-period in cycles; 0 = no program request.
REQ-008 Port prog_dir  input  1  program direction; bit 0 of direction register.
REQ-009 Port step_out  output  1  registered step pulse to driver.
REQ-010 Port dir_out  output  1  registered direction to driver.
REQ-011 Port owner  output  2  current grant: 0 NONE, 1 JOG, 2 PROG.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port position  output  32  signed step count, modulo 2^32.

Function
REQ-014 The block SHALL implement states IDLE, DIR_WAIT, PULSE_HIGH, PULSE_LOW.
REQ-015 The jog request SHALL be active only when exactly one of jog_fwd/jog_rev is high; both high = no jog request.
REQ-016 The program request SHALL be active when prog_speed != 0.
REQ-017 In IDLE, a jog request SHALL win over a program request (fixed priority); the winner SHALL be latched into owner, with its direction and half-period H (JOG_HALF or prog_speed) latched for the whole pulse.
REQ-018 In IDLE with no request, owner SHALL be NONE and step_out SHALL stay 0.
REQ-019 If the latched direction differs from dir_out, dir_out SHALL update on the IDLE exit edge and the FSM SHALL spend exactly DIR_SETUP cycles in DIR_WAIT before PULSE_HIGH.
REQ-020 If the direction is unchanged, IDLE SHALL go directly to PULSE_HIGH.
REQ-021 step_out SHALL be 1 for exactly H cycles (PULSE_HIGH), then 0 for H cycles (PULSE_LOW), then one IDLE cycle; steady-state period = 2H+1 (DIR_WAIT excluded).
REQ-022 position SHALL increment on each PULSE_HIGH entry when dir_out=0 and decrement when dir_out=1, wrapping modulo 2^32 (0xFFFFFFFF+1 = 0).
REQ-023 Request changes (release, priority change, prog_speed or prog_dir change) during DIR_WAIT/PULSE_HIGH/PULSE_LOW SHALL NOT abort or alter the pulse in progress; they take effect at the next IDLE evaluation.
REQ-024 Releasing the request during DIR_WAIT SHALL still complete the step (no partial pulse, no lost count).
REQ-025 Owner SHALL change only in IDLE; a jog press during a PROG pulse SHALL take effect after that pulse completes.
REQ-026 H = 1 SHALL be legal (period 3 cycles).

Reset
REQ-027 While reset is high: state IDLE, step_out 0, dir_out 0, owner NONE, busy 0, position 0, all counters 0, asynchronously and independent of clock.
REQ-028 Reset asserted mid-pulse SHALL force step_out low immediately; after release the FSM SHALL start from IDLE with no residual count.

Structure
REQ-029 The owner encodings and FSM state encodings SHALL live in a shared constants package for reuse by both axis instances and the wrapper.
REQ-030 The cycle counter used for H and DIR_SETUP SHALL be one sub-module, step_timer (load, count-down, done flag).
REQ-031 Two instances (X, Y) SHALL be used at the wrapper level; no cross-axis logic inside this block.

Verification (bench parameters JOG_HALF=4, DIR_SETUP=3)
REQ-032 Reset release, prog_speed=2, prog_dir=0 held -> owner=2, step_out pattern 1,1,0,0,idle repeating with period 5, position +1 per pulse.
REQ-033 jog_rev held from reset -> dir_out=1 at IDLE exit, 3 DIR_WAIT cycles with step_out 0, then high 4 / low 4, position decrements to 0xFFFFFFFF after first step.
REQ-034 prog_speed=6 running, jog_fwd asserted mid PULSE_HIGH -> current PROG pulse completes (6 high, 6 low), then owner=1 with H=4, no DIR_WAIT (same direction).
REQ-035 jog_fwd and jog_rev both high with prog_speed=0 -> owner stays 0, step_out stays 0, busy 0.
REQ-036 reset asserted in cycle 2 of PULSE_HIGH -> step_out 0 in same cycle, position 0, owner 0; after release and prog_speed=1 -> period 3 pulses resume.
REQ-037 Preload via 0xFFFFFFFF steps down then dir=0 steps -> position wraps 0xFFFFFFFF -> 0x00000000 correctly.
